// File: rtl/serial_load_ctrl.sv
// serial_load_ctrl
// Feeds the ACIA receive holding register from either the HPS text-file
// download (buffered in a small FIFO and paced at the selected baud rate so
// the guest software keeps up) or the physical UART receiver (passed straight
// through with 6850-style overrun detection).
module serial_load_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_FAST   = 50000,
    parameter int GAP_SLOW   = 1600000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       load_from,
    input  logic       baud_rate,
    input  logic       ioctl_download,
    input  logic       ioctl_wr,
    input  logic [7:0] ioctl_data,
    output logic       ioctl_wait,
    input  logic       uart_rx_valid,
    input  logic [7:0] uart_rx_data,
    output logic [7:0] acia_rx_data,
    output logic       acia_rx_full,
    input  logic       acia_rx_read,
    output logic       overrun,
    output logic       load_active
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int PW      = AW + 1;
    localparam int GAP_MAX = (GAP_FAST > GAP_SLOW) ? GAP_FAST : GAP_SLOW;
    localparam int GW      = $clog2(GAP_MAX + 1);

    localparam logic [GW-1:0] GAP_FAST_M1 = GW'(GAP_FAST - 1);
    localparam logic [GW-1:0] GAP_SLOW_M1 = GW'(GAP_SLOW - 1);
    localparam logic [PW-1:0] DEPTH_P     = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] WAIT_LEVEL  = PW'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FULL = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      data_q, data_d;
    logic            ovr_q, ovr_d;
    logic            wait_q, wait_d;
    logic            mode_q, mode_d;
    logic [7:0]      fifo_mem_q [FIFO_DEPTH];

    logic [PW-1:0]   count;
    logic            fifo_empty;
    logic            fifo_full;
    logic            mode_change;
    logic            file_push_req;
    logic            push;
    logic            ovr_set;
    logic [7:0]      head;

    assign count         = wr_ptr_q - rd_ptr_q;
    assign fifo_empty    = (count == '0);
    assign fifo_full     = (count == DEPTH_P);
    assign mode_change   = (load_from != mode_q);
    assign file_push_req = !load_from && ioctl_download && ioctl_wr && (ioctl_data != 8'h0A);
    assign push          = file_push_req && !fifo_full && !mode_change;
    assign head          = fifo_mem_q[rd_ptr_q[AW-1:0]];

    // Next-state logic: delivery FSM, FIFO pointers, overrun and back-pressure
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        wr_ptr_d = wr_ptr_q + (push ? PW'(1) : PW'(0));
        rd_ptr_d = rd_ptr_q;
        data_d   = data_q;
        ovr_set  = 1'b0;
        wait_d   = (count >= WAIT_LEVEL);
        mode_d   = load_from;

        case (state_q)
            S_IDLE: begin
                if (!load_from && !fifo_empty) begin
                    data_d   = head;
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    state_d  = S_FULL;
                end else if (load_from && uart_rx_valid) begin
                    data_d  = uart_rx_data;
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (acia_rx_read) begin
                    if (!load_from) begin
                        state_d = S_GAP;
                        gap_d   = baud_rate ? GAP_SLOW_M1 : GAP_FAST_M1;
                    end else if (uart_rx_valid) begin
                        data_d = uart_rx_data;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (load_from && uart_rx_valid) begin
                    ovr_set = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (file_push_req && fifo_full) begin
            ovr_set = 1'b1;
        end

        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (acia_rx_read) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end

        // A source switch abandons everything belonging to the old source
        if (mode_change) begin
            state_d  = S_IDLE;
            gap_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            data_d   = 8'h00;
            ovr_d    = 1'b0;
            wait_d   = 1'b0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= S_IDLE;
            gap_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= 8'h00;
            ovr_q    <= 1'b0;
            wait_q   <= 1'b0;
            mode_q   <= load_from;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            ovr_q    <= ovr_d;
            wait_q   <= wait_d;
            mode_q   <= mode_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate validity
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= ioctl_data;
        end
    end

    assign ioctl_wait   = wait_q;
    assign acia_rx_data = data_q;
    assign acia_rx_full = (state_q == S_FULL);
    assign overrun      = ovr_q;
    assign load_active  = ioctl_download || !fifo_empty || (!load_from && (state_q != S_IDLE));

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Testbench for serial_load_ctrl: directed scenarios followed by a random
// phase, every cycle compared against a queue-based behavioural model.
module tb_serial_load_ctrl;

    localparam int DEPTH = 16;
    localparam int GF    = 20;
    localparam int GS    = 70;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       load_from;
    logic       baud_rate;
    logic       ioctl_download;
    logic       ioctl_wr;
    logic [7:0] ioctl_data;
    logic       ioctl_wait;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic [7:0] acia_rx_data;
    logic       acia_rx_full;
    logic       acia_rx_read;
    logic       overrun;
    logic       load_active;

    serial_load_ctrl #(
        .FIFO_DEPTH(DEPTH),
        .GAP_FAST  (GF),
        .GAP_SLOW  (GS)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .load_from     (load_from),
        .baud_rate     (baud_rate),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_data    (ioctl_data),
        .ioctl_wait    (ioctl_wait),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .acia_rx_data  (acia_rx_data),
        .acia_rx_full  (acia_rx_full),
        .acia_rx_read  (acia_rx_read),
        .overrun       (overrun),
        .load_active   (load_active)
    );

    // 48 MHz-ish free-running clock (period is arbitrary in simulation)
    always #5 clk_sys = ~clk_sys;

    // Behavioural model: byte queue, holding register, pacing countdown
    logic [7:0] m_fifo[$];
    bit         m_full;
    logic [7:0] m_data;
    bit         m_ovr;
    bit         m_wait;
    int         m_gap;
    bit         m_prev_mode;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic model_clear();
        m_fifo.delete();
        m_full = 0;
        m_data = 8'h00;
        m_ovr  = 0;
        m_wait = 0;
        m_gap  = 0;
        m_prev_mode = load_from;
    endtask

    task automatic model_step();
        int  old_size;
        bit  old_full;
        bit  ovr_set;
        int  next_gap;
        old_size = m_fifo.size();
        old_full = m_full;
        ovr_set  = 0;
        if (reset || (load_from != m_prev_mode)) begin
            model_clear();
            return;
        end
        m_wait   = (old_size >= DEPTH - 2);
        next_gap = (m_gap > 0) ? m_gap - 1 : 0;
        if (!old_full) begin
            if (!load_from && m_gap == 0 && old_size > 0) begin
                m_data = m_fifo.pop_front();
                m_full = 1;
            end else if (load_from && uart_rx_valid) begin
                m_data = uart_rx_data;
                m_full = 1;
            end
        end else if (acia_rx_read) begin
            if (!load_from) begin
                m_full   = 0;
                next_gap = baud_rate ? GS : GF;
            end else if (uart_rx_valid) begin
                m_data = uart_rx_data;
            end else begin
                m_full = 0;
            end
        end else if (load_from && uart_rx_valid) begin
            ovr_set = 1;
        end
        m_gap = next_gap;
        if (!load_from && ioctl_download && ioctl_wr && ioctl_data != 8'h0A) begin
            if (old_size == DEPTH) ovr_set = 1;
            else m_fifo.push_back(ioctl_data);
        end
        if (ovr_set) m_ovr = 1;
        else if (acia_rx_read) m_ovr = 0;
    endtask

    task automatic checkOutput();
        bit exp_active;
        exp_active = ioctl_download || (m_fifo.size() > 0) || (!load_from && (m_full || m_gap > 0));
        check_val("acia_rx_full", acia_rx_full, m_full);
        check_val("acia_rx_data", acia_rx_data, m_data);
        check_val("overrun", overrun, m_ovr);
        check_val("ioctl_wait", ioctl_wait, m_wait);
        check_val("load_active", load_active, exp_active);
    endtask

    // One clock: inputs already driven; model follows the edge; outputs checked at negedge
    task automatic applyStimulus();
        @(posedge clk_sys);
        cycle++;
        model_step();
        @(negedge clk_sys);
        ioctl_wr      = 1'b0;
        uart_rx_valid = 1'b0;
        acia_rx_read  = 1'b0;
        checkOutput();
    endtask

    task automatic push_byte(input logic [7:0] b);
        ioctl_wr   = 1'b1;
        ioctl_data = b;
        applyStimulus();
    endtask

    // Read every byte presented until the load finishes or the bound expires
    task automatic drain(input string tag, input int bound, output logic [7:0] got[$]);
        int n;
        got.delete();
        n = 0;
        while (load_active && n < bound) begin
            if (acia_rx_full) begin
                got.push_back(acia_rx_data);
                acia_rx_read = 1'b1;
            end
            applyStimulus();
            n++;
        end
        check_val({tag, "_drain_done"}, load_active, 1'b0);
    endtask

    initial begin
        logic [7:0] got[$];
        logic [7:0] sent[$];
        int         read_edge;
        int         full_cycle;
        int         n;
        bit         saw_wait;

        reset = 1'b1; load_from = 1'b0; baud_rate = 1'b0;
        ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_data = 8'h00;
        uart_rx_valid = 1'b0; uart_rx_data = 8'h00; acia_rx_read = 1'b0;
        model_clear();
        @(negedge clk_sys);
        for (int i = 0; i < 3; i++) applyStimulus();
        reset = 1'b0;
        applyStimulus();
        check_val("reset_data", acia_rx_data, 8'h00);
        check_val("reset_full", acia_rx_full, 1'b0);

        // File load of "A\r\n" at the fast rate
        ioctl_download = 1'b1;
        push_byte(8'h41);
        push_byte(8'h0D);
        push_byte(8'h0A);
        ioctl_download = 1'b0;
        got.delete();
        read_edge = 0; full_cycle = 0; n = 0;
        while ((load_active || got.size() < 2) && n < 400) begin
            if (acia_rx_full) begin
                if (got.size() == 1) full_cycle = cycle;
                got.push_back(acia_rx_data);
                if (got.size() == 1) read_edge = cycle + 1;
                acia_rx_read = 1'b1;
            end
            applyStimulus();
            n++;
        end
        check_val("crlf_count", got.size(), 2);
        if (got.size() == 2) begin
            check_val("crlf_byte0", got[0], 8'h41);
            check_val("crlf_byte1", got[1], 8'h0D);
            check_val("crlf_spacing_ok", (full_cycle - read_edge) >= GF + 1, 1'b1);
        end
        check_val("crlf_active_end", load_active, 1'b0);

        // Burst of 20 with back-pressure honoured, reads starting late
        ioctl_download = 1'b1;
        sent.delete(); got.delete();
        saw_wait = 0; n = 0;
        while ((sent.size() < 20 || load_active) && n < 2000) begin
            if (ioctl_wait) saw_wait = 1;
            if (sent.size() == 20) ioctl_download = 1'b0;
            if (!ioctl_wait && sent.size() < 20) begin
                ioctl_wr   = 1'b1;
                ioctl_data = 8'($urandom_range(16, 255));
                sent.push_back(ioctl_data);
            end
            if (acia_rx_full && n > 25) begin
                got.push_back(acia_rx_data);
                acia_rx_read = 1'b1;
            end
            applyStimulus();
            n++;
        end
        check_val("burst_wait_seen", saw_wait, 1'b1);
        check_val("burst_count", got.size(), 20);
        for (int i = 0; i < 20 && i < got.size(); i++) check_val("burst_byte", got[i], sent[i]);

        // Forced pushes beyond capacity set overrun
        ioctl_download = 1'b1;
        for (int i = 0; i < 18; i++) push_byte(8'(8'h20 + i));
        check_val("fifo_overflow_ovr", overrun, 1'b1);
        ioctl_download = 1'b0;
        drain("overflow", 3000, got);
        check_val("overflow_ovr_cleared", overrun, 1'b0);

        // UART pass-through and overrun
        load_from = 1'b1;
        applyStimulus();
        uart_rx_valid = 1'b1; uart_rx_data = 8'h31; applyStimulus();
        check_val("uart_full", acia_rx_full, 1'b1);
        uart_rx_valid = 1'b1; uart_rx_data = 8'h32; applyStimulus();
        check_val("uart_keep_first", acia_rx_data, 8'h31);
        check_val("uart_ovr_set", overrun, 1'b1);
        acia_rx_read = 1'b1; applyStimulus();
        check_val("uart_ovr_clr", overrun, 1'b0);
        check_val("uart_empty", acia_rx_full, 1'b0);
        uart_rx_valid = 1'b1; uart_rx_data = 8'h30; applyStimulus();
        uart_rx_valid = 1'b1; uart_rx_data = 8'h33; acia_rx_read = 1'b1; applyStimulus();
        check_val("uart_swap_data", acia_rx_data, 8'h33);
        check_val("uart_swap_full", acia_rx_full, 1'b1);
        check_val("uart_swap_ovr", overrun, 1'b0);

        // Source switch with bytes pending flushes everything
        load_from = 1'b0; applyStimulus();
        ioctl_download = 1'b1;
        for (int i = 0; i < 6; i++) push_byte(8'(8'h50 + i));
        ioctl_download = 1'b0;
        load_from = 1'b1; applyStimulus();
        check_val("switch_full", acia_rx_full, 1'b0);
        check_val("switch_data", acia_rx_data, 8'h00);
        check_val("switch_active", load_active, 1'b0);

        // Slow pacing at 300 baud
        load_from = 1'b0; baud_rate = 1'b1; applyStimulus();
        ioctl_download = 1'b1;
        push_byte(8'h55);
        push_byte(8'h66);
        ioctl_download = 1'b0;
        n = 0;
        while (!acia_rx_full && n < 20) begin applyStimulus(); n++; end
        check_val("slow_first", acia_rx_data, 8'h55);
        acia_rx_read = 1'b1; read_edge = cycle + 1; applyStimulus();
        n = 0;
        while (!acia_rx_full && n < GS + 50) begin applyStimulus(); n++; end
        check_val("slow_second", acia_rx_data, 8'h66);
        check_val("slow_spacing_ok", (cycle - read_edge) >= GS + 1, 1'b1);
        acia_rx_read = 1'b1; applyStimulus();

        // Random phase against the model
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 399) == 0) load_from = ~load_from;
            if ($urandom_range(0, 199) == 0) baud_rate = ~baud_rate;
            if ($urandom_range(0, 59) == 0) ioctl_download = ~ioctl_download;
            ioctl_wr      = ($urandom_range(0, 2) == 0) && (!ioctl_wait || $urandom_range(0, 9) == 0);
            ioctl_data    = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
            uart_rx_valid = ($urandom_range(0, 7) == 0);
            uart_rx_data  = 8'($urandom);
            acia_rx_read  = acia_rx_full ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
            applyStimulus();
        end
        reset = 1'b0;
        applyStimulus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_load_ctrl.md
# serial_load_ctrl

Sequences bytes into the ACIA receive-data register from one of two sources: the HPS "Load Ascii" file download (ioctl stream) or the physical UART RX deserializer, selected by the OSD "Load programs from" option. File bytes are buffered in a small FIFO with host back-pressure (`ioctl_wait`) and paced at the selected baud rate so BASIC/monitor keep up. UART bytes pass straight through with 6850-style overrun. Sits between `hps_io`/UART RX and the ACIA receive side inside `uk101`.

## Interface
- `FIFO_DEPTH`, 16: file FIFO entries; power of two, ≥4.
- `GAP_FAST`, 50000: clocks between paced file bytes at 9600 baud (48 MHz / 960 char/s).
- `GAP_SLOW`, 1600000: clocks between paced file bytes at 300 baud.
- `clk_sys`  in  1  system clock, 48 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `load_from`  in  1  0 = file (ioctl), 1 = UART.
- `baud_rate`  in  1  0 = 9600 (`GAP_FAST`), 1 = 300 (`GAP_SLOW`).
- `ioctl_download`  in  1  download in progress.
- `ioctl_wr`  in  1  one-cycle strobe, `ioctl_data` valid.
- `ioctl_data`  in  8  downloaded byte.
- `ioctl_wait`  out  1  back-pressure to `hps_io`.
- `uart_rx_valid`  in  1  one-cycle strobe from UART deserializer.
- `uart_rx_data`  in  8  received UART byte.
- `acia_rx_data`  out  8  holding register, read by CPU via ACIA.
- `acia_rx_full`  out  1  RDRF: holding register valid.
- `acia_rx_read`  in  1  one-cycle pulse, CPU read of ACIA data register.
- `overrun`  out  1  sticky OVRN flag.
- `load_active`  out  1  file load in progress (LED).

## Operation
- States: `S_IDLE` (holding empty), `S_FULL` (holding valid), `S_GAP` (file mode pacing).
- File mode (`load_from`=0): `ioctl_wr` with `ioctl_download`=1 pushes `ioctl_data` into FIFO; byte 0x0A (LF) is discarded, all others stored unmodified. Push while FIFO full: byte dropped, `overrun` set.
- `ioctl_wait` = registered (count ≥ `FIFO_DEPTH`-2).
- `S_IDLE`, file mode, FIFO non-empty: pop head into `acia_rx_data`, -> `S_FULL`.
- `S_FULL`, `acia_rx_read`: file mode -> `S_GAP`, gap counter loaded with GAP-1 (GAP per current `baud_rate`); UART mode -> `S_IDLE`.
- `S_GAP`: counter decrements each cycle; at 0 -> `S_IDLE`. `baud_rate` change takes effect at next load only.
- UART mode (`load_from`=1): FIFO not pushed, ioctl bytes ignored. `uart_rx_valid` in `S_IDLE` loads holding, -> `S_FULL`. In `S_FULL` without same-cycle `acia_rx_read`: byte dropped, `overrun` set. With same-cycle `acia_rx_read`: new byte loaded, stays `S_FULL`, no overrun.
- `overrun` cleared by `acia_rx_read` (set takes priority if both occur same cycle).
- Any change of `load_from` (edge vs registered copy): FIFO flushed, holding cleared, gap cleared, -> `S_IDLE`, `overrun` cleared.
- `load_active` = `ioctl_download` | FIFO non-empty | (`load_from`=0 & state≠`S_IDLE`).
- FIFO pointers width log2(`FIFO_DEPTH`)+1; wrap naturally; count = wr-rd modulo 2·DEPTH.

## Timing
- Reset values: `acia_rx_data`=0x00, `acia_rx_full`=0, `ioctl_wait`=0, `overrun`=0, `load_active`=0, FIFO empty, state `S_IDLE`, gap counter 0.
- File latency: `ioctl_wr` sampled at edge N -> pop at edge N+1 -> `acia_rx_full`=1 after N+1 (2 cycles), when `S_IDLE`.
- UART latency: `uart_rx_valid` at edge N -> `acia_rx_full`=1 after N.
- `acia_rx_full` falls the cycle after `acia_rx_read`.
- Next file byte: earliest GAP+1 cycles after `acia_rx_read` edge.
- `ioctl_wait` rises one cycle after count reaches DEPTH-2; the one in-flight byte still fits.
- Reset mid-download: all state cleared; remaining bytes after reset still accepted normally.

## Test plan
- Reset: hold `reset` 3 cycles mid-`S_FULL` -> all outputs at reset values next cycle, FIFO empty.
- File load "A\r\n" (0x41,0x0D,0x0A), baud 9600, CPU reads on each RDRF -> CPU sees 0x41 then 0x0D, spacing ≥50001 clocks, 0x0A never presented, `load_active` falls after final read+gap.
- Burst 20 `ioctl_wr` back-to-back, no reads, DEPTH 16 -> `ioctl_wait`=1 one cycle after 14th stored; bench honouring wait loses nothing; forced 17th push into full FIFO sets `overrun`.
- UART: two `uart_rx_valid` (0x31, 0x32) without read -> `acia_rx_data`=0x31, `overrun`=1; read -> `overrun`=0, full=0; 0x33 with same-cycle read -> data 0x33, full=1, `overrun`=0.
- Toggle `load_from` 0->1 with 5 bytes in FIFO -> next cycle FIFO empty, `acia_rx_full`=0, state `S_IDLE`.
- Baud 300: read at cycle T -> next file byte RDRF no earlier than T+1600001.
